blink_frame_gen: RTL and testbench

//  - Pixel source feeding the animation mux ahead of spi_lcd.
//  - Returns an RGB565 pixel for each (x,y) address scanned by the LCD driver.
//  - Draws two rectangular "eyes" that blink periodically.
//  - The lid level changes only at frame boundaries, so a frame never tears.

---
 rtl/blink_frame_gen.sv | 182 ++++++++++++++++++
 tb/tb_blink_frame_gen.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/blink_frame_gen.sv
// rtl/blink_frame_gen.sv - blinking-eyes RGB565 pixel source; optional random blink period under BLINK_RANDOM_EN
module blink_frame_gen #(
    parameter int          LCD_W         = 132,
    parameter int          LCD_H         = 162,
    parameter int          EYE_W         = 24,
    parameter int          EYE_H         = 32,
    parameter int          EYE_Y0        = 50,
    parameter int          EYE_LX0       = 30,
    parameter int          EYE_RX0       = 78,
    parameter int          LID_STEP      = 4,
    parameter int          BLINK_PERIOD  = 90,
    parameter int          CLOSED_FRAMES = 3,
    parameter logic [15:0] FG            = 16'hFFFF,
    parameter logic [15:0] BG            = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ram_addr_x,
    input  logic [7:0]  ram_addr_y,
    input  logic        blink_now,
    output logic [15:0] ram_data,
    output logic        blinking
);

`ifdef BLINK_RANDOM_EN
    localparam int CNT_W = 9;
`else
    localparam int CNT_W = 8;
`endif

    typedef enum logic [1:0] {OPEN, CLOSING, CLOSED, OPENING} state_t;

    // Geometry bounds held in 9 bits so the comparisons cannot wrap
    localparam logic [8:0] X_MAX  = 9'(LCD_W);
    localparam logic [8:0] Y_MAX  = 9'(LCD_H);
    localparam logic [8:0] LX_LO  = 9'(EYE_LX0);
    localparam logic [8:0] LX_HI  = 9'(EYE_LX0 + EYE_W);
    localparam logic [8:0] RX_LO  = 9'(EYE_RX0);
    localparam logic [8:0] RX_HI  = 9'(EYE_RX0 + EYE_W);
    localparam logic [8:0] Y_LO   = 9'(EYE_Y0);
    localparam logic [8:0] Y_HI   = 9'(EYE_Y0 + EYE_H);

    localparam logic [5:0] LID_MAX = 6'(EYE_H);
    localparam logic [5:0] LID_INC = 6'(LID_STEP);
    localparam logic [CNT_W-1:0] CLOSED_M1 = CNT_W'(CLOSED_FRAMES - 1);

    state_t           state;
    logic [5:0]       lid;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] period_m1;
    logic [7:0]       prev_x;
    logic [7:0]       prev_y;
    logic             tick;

    logic [8:0] x9;
    logic [8:0] y9;
    logic [8:0] dy;
    logic       in_panel;
    logic       in_eye_x;
    logic       in_eye_y;
    logic       eye_hit;
    logic [6:0] lid_sum;
    logic [5:0] lid_up;
    logic [5:0] lid_dn;

    assign tick = (ram_addr_x == 8'd0) && (ram_addr_y == 8'd0) &&
                  ((prev_x != 8'd0) || (prev_y != 8'd0));

    assign x9       = {1'b0, ram_addr_x};
    assign y9       = {1'b0, ram_addr_y};
    assign dy       = y9 - Y_LO;
    assign in_panel = (x9 < X_MAX) && (y9 < Y_MAX);
    assign in_eye_x = ((x9 >= LX_LO) && (x9 < LX_HI)) || ((x9 >= RX_LO) && (x9 < RX_HI));
    assign in_eye_y = (y9 >= Y_LO) && (y9 < Y_HI);
    assign eye_hit  = in_panel && in_eye_x && in_eye_y && (dy >= {3'b000, lid});

    // Lid moves saturate at fully closed and fully open
    assign lid_sum = {1'b0, lid} + {1'b0, LID_INC};
    assign lid_up  = (lid_sum >= {1'b0, LID_MAX}) ? LID_MAX : lid_sum[5:0];
    assign lid_dn  = (lid <= LID_INC) ? 6'd0 : (lid - LID_INC);

`ifdef BLINK_RANDOM_EN
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    logic [7:0] lfsr;
    logic [8:0] period;
    logic       enter_open;

    assign enter_open = tick && (state == OPENING) && (lid_dn == 6'd0);
    assign period_m1  = period - 9'd1;

    // LFSR advances once per frame; a fresh period is latched whenever the eyes reopen
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr   <= LFSR_SEED;
            period <= 9'(BLINK_PERIOD) + {3'b000, LFSR_SEED[5:0]};
        end else begin
            if (tick) begin
                lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            end
            if (enter_open) begin
                period <= 9'(BLINK_PERIOD) + {3'b000, lfsr[5:0]};
            end
        end
    end
`else
    assign period_m1 = CNT_W'(BLINK_PERIOD - 1);
`endif

    // Remember the last address so a return to (0,0) marks a new frame
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_x <= 8'd0;
            prev_y <= 8'd0;
        end else begin
            prev_x <= ram_addr_x;
            prev_y <= ram_addr_y;
        end
    end

    // One-cycle pixel pipeline using the lid level of the current frame
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_data <= BG;
        end else begin
            ram_data <= eye_hit ? FG : BG;
        end
    end

    // Blink sequencer: lid and state only move on frame ticks, except the blink_now kick-off
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= OPEN;
            lid       <= 6'd0;
            frame_cnt <= '0;
            blinking  <= 1'b0;
        end else begin
            case (state)
                OPEN: begin
                    if (blink_now || (tick && (frame_cnt == period_m1))) begin
                        state     <= CLOSING;
                        frame_cnt <= '0;
                        blinking  <= 1'b1;
                    end else if (tick) begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
                CLOSING: begin
                    if (tick) begin
                        lid <= lid_up;
                        if (lid_up == LID_MAX) begin
                            state <= CLOSED;
                        end
                    end
                end
                CLOSED: begin
                    if (tick) begin
                        if (frame_cnt == CLOSED_M1) begin
                            state     <= OPENING;
                            frame_cnt <= '0;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                OPENING: begin
                    if (tick) begin
                        lid <= lid_dn;
                        if (lid_dn == 6'd0) begin
                            state    <= OPEN;
                            blinking <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= OPEN;
                    blinking <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blink_frame_gen.sv
// tb/tb_blink_frame_gen.sv - directed self-checking bench for blink_frame_gen
module tb_blink_frame_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ram_addr_x;
    logic [7:0]  ram_addr_y;
    logic        blink_now;
    logic [15:0] ram_data;
    logic        blinking;

    int tests = 0;
    int fails = 0;
    logic [15:0] d;

    blink_frame_gen dut (
        .clk        (clk),
        .rst        (rst),
        .ram_addr_x (ram_addr_x),
        .ram_addr_y (ram_addr_y),
        .blink_now  (blink_now),
        .ram_data   (ram_data),
        .blinking   (blinking)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present an address for one clock and return the pixel produced for it
    task automatic px(input int x, input int y, output logic [15:0] data);
        @(negedge clk);
        ram_addr_x = 8'(x);
        ram_addr_y = 8'(y);
        @(negedge clk);
        data = ram_data;
    endtask

    // Short frame: leave (0,0) then return to it, producing exactly one tick
    task automatic frame();
        @(negedge clk);
        ram_addr_x = 8'd1;
        ram_addr_y = 8'd0;
        @(negedge clk);
        ram_addr_x = 8'd0;
        ram_addr_y = 8'd0;
        @(negedge clk);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic pulse_blink();
        @(negedge clk);
        blink_now = 1'b1;
        @(negedge clk);
        blink_now = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        blink_now  = 1'b0;
        ram_addr_x = 8'd30;
        ram_addr_y = 8'd50;
        repeat (3) @(negedge clk);
        chk("rst_data", ram_data, 16'h0000);
        chk("rst_blinking", {15'd0, blinking}, 16'd0);
        rst = 1'b0;

        // Latency and eye geometry edges
        px(30, 50, d);  chk("t1_lx0", d, 16'hFFFF);
        px(29, 50, d);  chk("t1_lx0_m1", d, 16'h0000);
        px(78, 81, d);  chk("t1_rx0_lastrow", d, 16'hFFFF);
        px(53, 60, d);  chk("t1_lx_last", d, 16'hFFFF);
        px(54, 60, d);  chk("t1_lx_end", d, 16'h0000);
        px(101, 60, d); chk("t1_rx_last", d, 16'hFFFF);
        px(102, 60, d); chk("t1_rx_end", d, 16'h0000);
        px(30, 49, d);  chk("t1_y_above", d, 16'h0000);
        px(30, 82, d);  chk("t1_y_below", d, 16'h0000);

        // Out of panel
        px(140, 10, d); chk("t2_x_out", d, 16'h0000);
        px(10, 170, d); chk("t2_y_out", d, 16'h0000);

        // Automatic blink after 90 frames
        frames(89);
        chk("t3_open_89", {15'd0, blinking}, 16'd0);
        frame();
        chk("t3_closing_90", {15'd0, blinking}, 16'd1);
        px(30, 50, d);  chk("t3_lid0_row0", d, 16'hFFFF);
        frame();
        px(30, 53, d);  chk("t3_lid4_row3", d, 16'h0000);
        px(30, 54, d);  chk("t3_lid4_row4", d, 16'hFFFF);
        frame();
        px(30, 57, d);  chk("t5_lid8_row7", d, 16'h0000);
        px(30, 58, d);  chk("t5_lid8_row8", d, 16'hFFFF);
        px(30, 58, d);  chk("t5_lid8_stable", d, 16'hFFFF);
        frames(6);
        px(30, 81, d);  chk("t3_closed_l", d, 16'h0000);
        px(78, 81, d);  chk("t3_closed_r", d, 16'h0000);
        frames(3);
        chk("t3_opening_blinking", {15'd0, blinking}, 16'd1);
        px(30, 81, d);  chk("t3_still_closed", d, 16'h0000);
        frame();
        px(30, 77, d);  chk("t3_lid28_row27", d, 16'h0000);
        px(30, 78, d);  chk("t3_lid28_row28", d, 16'hFFFF);
        frames(7);
        chk("t3_reopened", {15'd0, blinking}, 16'd0);
        px(30, 50, d);  chk("t3_open_row0", d, 16'hFFFF);

        // blink_now in OPEN, then ignored while CLOSED
        frames(10);
        chk("t4_open_10", {15'd0, blinking}, 16'd0);
        pulse_blink();
        chk("t4_blink_now", {15'd0, blinking}, 16'd1);
        px(30, 50, d);  chk("t4_lid_unmoved", d, 16'hFFFF);
        frames(8);
        frame();
        pulse_blink();
        chk("t4_closed_blinking", {15'd0, blinking}, 16'd1);
        frames(2);
        frame();
        px(30, 78, d);  chk("t4_ignore_row28", d, 16'hFFFF);
        px(30, 77, d);  chk("t4_ignore_row27", d, 16'h0000);

        // Reset while CLOSED
        frames(7);
        chk("t6_open_again", {15'd0, blinking}, 16'd0);
        pulse_blink();
        frames(8);
        chk("t6_closed_blinking", {15'd0, blinking}, 16'd1);
        px(30, 60, d);  chk("t6_closed_pix", d, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_data", ram_data, 16'h0000);
        chk("t6_rst_blinking", {15'd0, blinking}, 16'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_full_eye", ram_data, 16'hFFFF);
        frame();
        px(78, 81, d);  chk("t6_next_frame", d, 16'hFFFF);
        chk("t6_blinking_low", {15'd0, blinking}, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
